// File: rtl/jedro_1_test_pkg.sv
// Shared types and helpers for the jedro_1 test sequencer.
package jedro_1_test_pkg;

  // Run-controller states, in the order a normal run visits them.
  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_ADDR,
    S_CMP,
    S_DONE
  } seq_state_e;

  // Index width that stays legal (>=1 bit) even for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/jedro_1_check_table.sv
// Check table: MAX_CHECKS {register address, expected value} entries,
// one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset so a table survives core re-runs.
module jedro_1_check_table
  import jedro_1_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MAX_CHECKS     = 8
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [idx_w(MAX_CHECKS)-1:0]  wr_idx_i,
  input  logic [REG_ADDR_WIDTH-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0]         wr_val_i,
  input  logic [idx_w(MAX_CHECKS)-1:0]  rd_idx_i,
  output logic [REG_ADDR_WIDTH-1:0]     rd_addr_o,
  output logic [DATA_WIDTH-1:0]         rd_val_o
);

  localparam int unsigned IDX_W = idx_w(MAX_CHECKS);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]     val;
  } check_entry_t;

  check_entry_t entry_q [MAX_CHECKS];
  check_entry_t rd_entry;
  logic         wr_ok;
  logic         rd_ok;

  // Out-of-range indices only exist when MAX_CHECKS is not a power of two.
  if ((2 ** IDX_W) == MAX_CHECKS) begin : g_pow2
    assign wr_ok = 1'b1;
    assign rd_ok = 1'b1;
  end else begin : g_npow2
    assign wr_ok = (wr_idx_i < IDX_W'(MAX_CHECKS));
    assign rd_ok = (rd_idx_i < IDX_W'(MAX_CHECKS));
  end

  // Single write port; no reset on the storage.
  always_ff @(posedge clk_i) begin
    if (we_i && wr_ok) begin
      entry_q[wr_idx_i] <= '{addr: wr_addr_i, val: wr_val_i};
    end
  end

  assign rd_entry  = rd_ok ? entry_q[rd_idx_i] : '0;
  assign rd_addr_o = rd_entry.addr;
  assign rd_val_o  = rd_entry.val;

endmodule

// File: rtl/jedro_1_test_sequencer.sv
// Self-checking run controller for jedro_1 instruction tests: resets the
// core, runs it until an illegal instruction or the cycle budget, drains,
// then reads back and compares up to MAX_CHECKS regfile entries.
module jedro_1_test_sequencer
  import jedro_1_test_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned MAX_CHECKS     = 8,
  parameter int unsigned MAX_CYCLES     = 32,
  parameter int unsigned DRAIN_CYCLES   = 3,
  parameter int unsigned RESET_CYCLES   = 3
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              start_i,
  input  logic [$clog2(MAX_CHECKS+1)-1:0]   num_checks_i,
  input  logic                              chk_we_i,
  input  logic [idx_w(MAX_CHECKS)-1:0]      chk_idx_i,
  input  logic [REG_ADDR_WIDTH-1:0]         chk_addr_i,
  input  logic [DATA_WIDTH-1:0]             chk_val_i,
  output logic                              core_rstn_o,
  input  logic                              illegal_instr_i,
  output logic [REG_ADDR_WIDTH-1:0]         reg_raddr_o,
  input  logic [DATA_WIDTH-1:0]             reg_rdata_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              pass_o,
  output logic                              illegal_stop_o,
  output logic                              timeout_o,
  output logic [$clog2(MAX_CHECKS+1)-1:0]   err_count_o,
  output logic [idx_w(MAX_CHECKS)-1:0]      first_err_idx_o,
  output logic [DATA_WIDTH-1:0]             first_err_data_o
);

  localparam int unsigned CNT_W = $clog2(MAX_CHECKS + 1);
  localparam int unsigned IDX_W = idx_w(MAX_CHECKS);
  localparam int unsigned CYC_W = idx_w(MAX_CYCLES);
  localparam int unsigned PH_W  = idx_w((RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES);

  seq_state_e                state_q, state_d;
  logic [CYC_W-1:0]          cyc_q, cyc_d;
  logic [PH_W-1:0]           ph_q, ph_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          num_q, num_d;
  logic [CNT_W-1:0]          err_q, err_d;
  logic [IDX_W-1:0]          ferr_idx_q, ferr_idx_d;
  logic [DATA_WIDTH-1:0]     ferr_data_q, ferr_data_d;
  logic                      illegal_q, illegal_d;
  logic                      timeout_q, timeout_d;
  logic                      core_rstn_q, core_rstn_d;
  logic [REG_ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DATA_WIDTH-1:0]     exp_q, exp_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      pass_q, pass_d;

  logic [IDX_W-1:0]          rd_idx;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]     rd_val;

  // The table is frozen while a run is in flight.
  jedro_1_check_table #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .MAX_CHECKS     (MAX_CHECKS)
  ) u_table (
    .clk_i     (clk_i),
    .we_i      (chk_we_i && !busy_q),
    .wr_idx_i  (chk_idx_i),
    .wr_addr_i (chk_addr_i),
    .wr_val_i  (chk_val_i),
    .rd_idx_i  (rd_idx),
    .rd_addr_o (rd_addr),
    .rd_val_o  (rd_val)
  );

  // Read ahead the entry the next ADDR state will present: entry 0 when
  // leaving DRAIN, idx+1 when leaving CMP.
  assign rd_idx = (state_q == S_CMP) ? idx_q + IDX_W'(1) : '0;

  // Next-state and next-output logic for the whole run sequence.
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    ph_d        = ph_q;
    idx_d       = idx_q;
    num_d       = num_q;
    err_d       = err_q;
    ferr_idx_d  = ferr_idx_q;
    ferr_data_d = ferr_data_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    core_rstn_d = core_rstn_q;
    raddr_d     = raddr_q;
    exp_d       = exp_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_RESET;
          ph_d        = '0;
          err_d       = '0;
          ferr_idx_d  = '0;
          ferr_data_d = '0;
          illegal_d   = 1'b0;
          timeout_d   = 1'b0;
          core_rstn_d = 1'b0;
          num_d       = (num_checks_i > CNT_W'(MAX_CHECKS)) ? CNT_W'(MAX_CHECKS) : num_checks_i;
        end
      end
      S_RESET: begin
        if (ph_q == PH_W'(RESET_CYCLES - 1)) begin
          state_d     = S_RUN;
          cyc_d       = '0;
          core_rstn_d = 1'b1;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_RUN: begin
        // Illegal instruction wins over a simultaneous budget expiry.
        if (illegal_instr_i) begin
          illegal_d = 1'b1;
          state_d   = S_DRAIN;
          ph_d      = '0;
        end else if (cyc_q == CYC_W'(MAX_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_DRAIN;
          ph_d      = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_DRAIN: begin
        if (ph_q == PH_W'(DRAIN_CYCLES - 1)) begin
          if (num_q != '0) begin
            state_d = S_ADDR;
            idx_d   = '0;
            raddr_d = rd_addr;
            exp_d   = rd_val;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      S_ADDR: begin
        // Regfile read is in flight; data arrives during CMP.
        state_d = S_CMP;
      end
      S_CMP: begin
        if (reg_rdata_i != exp_q) begin
          err_d = err_q + CNT_W'(1);
          if (err_q == '0) begin
            ferr_idx_d  = idx_q;
            ferr_data_d = reg_rdata_i;
          end
        end
        if ((CNT_W'(idx_q) + CNT_W'(1)) == num_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ADDR;
          idx_d   = idx_q + IDX_W'(1);
          raddr_d = rd_addr;
          exp_d   = rd_val;
        end
      end
      default: begin
        state_d     = S_IDLE;
        core_rstn_d = 1'b0;
      end
    endcase

    busy_d = state_d inside {S_RESET, S_RUN, S_DRAIN, S_ADDR, S_CMP};
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  // State and registered outputs; table contents are outside this reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      ph_q        <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      err_q       <= '0;
      ferr_idx_q  <= '0;
      ferr_data_q <= '0;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      core_rstn_q <= 1'b0;
      raddr_q     <= '0;
      exp_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      err_q       <= err_d;
      ferr_idx_q  <= ferr_idx_d;
      ferr_data_q <= ferr_data_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      core_rstn_q <= core_rstn_d;
      raddr_q     <= raddr_d;
      exp_q       <= exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign core_rstn_o      = core_rstn_q;
  assign reg_raddr_o      = raddr_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign illegal_stop_o   = illegal_q;
  assign timeout_o        = timeout_q;
  assign err_count_o      = err_q;
  assign first_err_idx_o  = ferr_idx_q;
  assign first_err_data_o = ferr_data_q;

endmodule

// File: tb/tb_jedro_1_test_sequencer.sv
// Bench for jedro_1_test_sequencer: a behavioural core/regfile stand-in
// plus a run-level reference model (expected latency, stop reason, errors).
module tb_jedro_1_test_sequencer;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int MC  = 8;
  localparam int MCY = 32;
  localparam int DR  = 3;
  localparam int RC  = 3;
  localparam int CW  = $clog2(MC + 1);
  localparam int IW  = $clog2(MC);
  localparam int NO_ILLEGAL = 100000;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] num_checks_i = '0;
  logic          chk_we_i = 1'b0;
  logic [IW-1:0] chk_idx_i = '0;
  logic [AW-1:0] chk_addr_i = '0;
  logic [DW-1:0] chk_val_i = '0;
  logic          core_rstn_o;
  logic          illegal_instr_i = 1'b0;
  logic [AW-1:0] reg_raddr_o;
  logic [DW-1:0] reg_rdata_i = '0;
  logic          busy_o, done_o, pass_o, illegal_stop_o, timeout_o;
  logic [CW-1:0] err_count_o;
  logic [IW-1:0] first_err_idx_o;
  logic [DW-1:0] first_err_data_o;

  jedro_1_test_sequencer #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .MAX_CHECKS(MC),
    .MAX_CYCLES(MCY), .DRAIN_CYCLES(DR), .RESET_CYCLES(RC)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .num_checks_i(num_checks_i),
    .chk_we_i(chk_we_i), .chk_idx_i(chk_idx_i), .chk_addr_i(chk_addr_i), .chk_val_i(chk_val_i),
    .core_rstn_o(core_rstn_o), .illegal_instr_i(illegal_instr_i),
    .reg_raddr_o(reg_raddr_o), .reg_rdata_i(reg_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .illegal_stop_o(illegal_stop_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
    .first_err_idx_o(first_err_idx_o), .first_err_data_o(first_err_data_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int run_no = 0;

  logic [DW-1:0] regs [32];
  logic [AW-1:0] tbl_addr [MC];
  logic [DW-1:0] tbl_val [MC];
  int rc = 0;
  int ill_at = NO_ILLEGAL;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: regfile answers the address seen last cycle; the core model
  // raises illegal_instr on its ill_at-th cycle out of reset (noise while held).
  task automatic tick();
    logic [AW-1:0] a;
    logic          was;
    a   = reg_raddr_o;
    was = core_rstn_o;
    @(posedge clk_i);
    #1;
    reg_rdata_i = (a == '0) ? '0 : regs[a];
    if (!core_rstn_o)  rc = 0;
    else if (was)      rc++;
    else               rc = 0;
    illegal_instr_i = core_rstn_o ? (rc == ill_at) : 1'($urandom_range(0, 1));
  endtask

  task automatic write_entry(input int i, input int a, input logic [DW-1:0] v);
    chk_we_i   = 1'b1;
    chk_idx_i  = IW'(i);
    chk_addr_i = AW'(a);
    chk_val_i  = v;
    tick();
    chk_we_i   = 1'b0;
    tbl_addr[i] = AW'(a);
    tbl_val[i]  = v;
  endtask

  // Start a run and compare every observable result with the model.
  task automatic run_test(input int num, input int ia, input bit disturb);
    int n, exp_n, stop_n, low, run_len, nchk, errs, fi;
    logic [DW-1:0] fd, got;
    bit exp_ill;
    ill_at  = ia;
    exp_ill = (ia < MCY);
    run_len = exp_ill ? ia + 1 : MCY;
    nchk    = (num > MC) ? MC : num;
    errs = 0; fi = 0; fd = '0;
    for (int i = 0; i < nchk; i++) begin
      got = (tbl_addr[i] == '0) ? '0 : regs[tbl_addr[i]];
      if (got != tbl_val[i]) begin
        if (errs == 0) begin fi = i; fd = got; end
        errs++;
      end
    end
    exp_n = RC + run_len + DR + 2 * nchk;

    num_checks_i = CW'(num);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    num_checks_i = CW'($urandom_range(0, 15));
    n = 0;
    low = core_rstn_o ? 0 : 1;
    stop_n = -1;
    while (!done_o && n < 2000) begin
      if (disturb && n == RC + 3) begin
        start_i    = 1'b1;
        num_checks_i = '0;
        chk_we_i   = 1'b1;
        chk_idx_i  = '0;
        chk_addr_i = tbl_addr[0] ^ AW'(1);
        chk_val_i  = ~tbl_val[0];
      end
      tick();
      n++;
      start_i  = 1'b0;
      chk_we_i = 1'b0;
      if (!core_rstn_o) low++;
      if (stop_n < 0 && (illegal_stop_o || timeout_o)) stop_n = n;
    end
    check_val("done_seen",    done_o, 1);
    check_val("latency",      n, exp_n);
    check_val("rst_low",      low, RC);
    check_val("stop_at",      stop_n, RC + run_len);
    check_val("illegal_stop", illegal_stop_o, exp_ill);
    check_val("timeout",      timeout_o, !exp_ill);
    check_val("err_count",    err_count_o, errs);
    check_val("pass",         pass_o, (errs == 0));
    check_val("first_idx",    first_err_idx_o, fi);
    check_val("first_data",   first_err_data_o, fd);
    check_val("busy_done",    busy_o, 0);
    check_val("core_rstn",    core_rstn_o, 1);
    $display("run %0d: num=%0d ill_at=%0d -> cycles=%0d errs=%0d/%0d first=%0d data=%0h",
             run_no, num, ia, n, err_count_o, errs, first_err_idx_o, first_err_data_o);
    run_no++;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_core_rstn"}, core_rstn_o, 0);
    check_val({tag, "_raddr"},     reg_raddr_o, 0);
    check_val({tag, "_busy"},      busy_o, 0);
    check_val({tag, "_done"},      done_o, 0);
    check_val({tag, "_pass"},      pass_o, 0);
    check_val({tag, "_illegal"},   illegal_stop_o, 0);
    check_val({tag, "_timeout"},   timeout_o, 0);
    check_val({tag, "_err"},       err_count_o, 0);
    check_val({tag, "_fidx"},      first_err_idx_o, 0);
    check_val({tag, "_fdata"},     first_err_data_o, 0);
  endtask

  initial begin
    int a;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = '0;

    rstn_i = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    rstn_i = 1'b1;
    tick();

    // AND-style result in x1/x2, illegal instruction at cycle 10.
    regs[1] = 32'd7; regs[2] = 32'd7;
    write_entry(0, 1, 32'd7);
    write_entry(1, 2, 32'd7);
    run_test(2, 10, 1'b0);

    // Single mismatch: expect 14, register holds 7.
    write_entry(0, 1, 32'd14);
    run_test(1, 5, 1'b0);

    // No illegal instruction: budget expiry, checks still run.
    write_entry(0, 1, 32'd7);
    run_test(2, NO_ILLEGAL, 1'b0);

    // Vacuous pass.
    run_test(0, 4, 1'b0);

    // Eight checks, x0 included, mismatches at 2, 5 and 7.
    write_entry(0, 0, 32'd0);
    for (int i = 1; i < MC; i++)
      write_entry(i, i, (i == 2 || i == 5 || i == 7) ? regs[i] ^ 32'h0000_0100 : regs[i]);
    run_test(8, 6, 1'b0);

    // Illegal on the last budget cycle takes priority; oversized num clamps.
    run_test(8, MCY - 1, 1'b0);
    run_test(12, 3, 1'b0);

    // Start and table writes while busy are ignored.
    run_test(3, NO_ILLEGAL, 1'b1);

    // Reset abort during RUN.
    ill_at = NO_ILLEGAL;
    num_checks_i = CW'(2);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (RC + 4) tick();
    check_val("abort_busy_pre", busy_o, 1);
    check_val("abort_core_pre", core_rstn_o, 1);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;
    check_idle("abort");
    run_test(8, 2, 1'b0);

    // Randomized runs against the model.
    for (int it = 0; it < 20; it++) begin
      for (int r = 1; r < 32; r++) if ($urandom_range(0, 3) == 0) regs[r] = $urandom;
      for (int i = 0; i < MC; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          a = $urandom_range(0, 31);
          write_entry(i, a, ($urandom_range(0, 3) == 0)
                            ? ((a == 0 ? 32'd0 : regs[a]) ^ (32'h1 << $urandom_range(0, 31)))
                            : (a == 0 ? 32'd0 : regs[a]));
        end
      end
      run_test($urandom_range(0, 15), $urandom_range(0, MCY + 8), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
